axi_rd_arbiter_rv32: RTL and testbench

- Two-master, one-slave arbiter for the AXI-lite read channels (AR/R).
- Shares the single memory read port between the instruction fetch unit (IFU) and the load path of the LSU.
- Sits between those two units and the SRAM/bus read port.
- Holds exactly one outstanding transaction at a time, and steers the R response back to the requester that was granted.

---
 rtl/axi_rd_arbiter_rv32_if.sv | 23 ++
 rtl/axi_rd_arbiter_rv32.sv | 98 +++++++++
 tb/tb_axi_rd_arbiter_rv32.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_rd_arbiter_rv32_if.sv
// AXI-lite read channel (AR + R) bundle. "master" drives AR and R-ready,
// "slave" returns AR-ready and the R beat.
interface axi_rd_arbiter_rv32_if #(
    parameter int DATA_LEN = 32
);
    logic                arvalid;
    logic                arready;
    logic [DATA_LEN-1:0] araddr;
    logic                rvalid;
    logic                rready;
    logic [2:0]          rresp;
    logic [DATA_LEN-1:0] rdata;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rresp, rdata
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rresp, rdata
    );
endinterface

// File: rtl/axi_rd_arbiter_rv32.sv
// Two-master (IFU, LSU) to one-slave AXI-lite read arbiter, one transaction in flight.
// Define ARB_ROUND_ROBIN_EN for alternating grant on contention; default is fixed LSU priority.
module axi_rd_arbiter_rv32 #(
    parameter int DATA_LEN = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    axi_rd_arbiter_rv32_if.slave   ifu,
    axi_rd_arbiter_rv32_if.slave   lsu,
    axi_rd_arbiter_rv32_if.master  m
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_e;
    typedef enum logic [1:0] {G_NONE = 2'd0, G_IFU = 2'd1, G_LSU = 2'd2} grant_e;

    state_e state_q, state_d;
    grant_e grant_q, grant_d;
    grant_e winner;
    logic   busy, done, rready_sel, r_fire;

    assign busy       = (state_q == S_ADDR) || (state_q == S_DATA);
    assign rready_sel = busy && ((grant_q == G_LSU) ? lsu.rready :
                                 (grant_q == G_IFU) ? ifu.rready : 1'b0);
    assign r_fire     = m.rvalid && rready_sel;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the LSU owned the most recently completed transaction.
    logic last_lsu_q, last_lsu_d;

    assign last_lsu_d = done ? (grant_q == G_LSU) : last_lsu_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_lsu_q <= 1'b0;
        else        last_lsu_q <= last_lsu_d;
    end
`endif

    always_comb begin
        winner = G_NONE;
        if (lsu.arvalid)      winner = G_LSU;
        else if (ifu.arvalid) winner = G_IFU;
`ifdef ARB_ROUND_ROBIN_EN
        if (lsu.arvalid && ifu.arvalid && last_lsu_q) winner = G_IFU;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            grant_q <= G_NONE;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                grant_d = winner;
                if (winner != G_NONE) state_d = S_ADDR;
            end
            // Address and first data beat may both complete in one cycle.
            S_ADDR: begin
                if (m.arready && r_fire) done = 1'b1;
                else if (m.arready)      state_d = S_DATA;
            end
            S_DATA: begin
                if (r_fire) done = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = G_NONE;
            end
        endcase
        // A busy state without a real owner can never finish; recover to idle.
        if (done || (busy && grant_q != G_IFU && grant_q != G_LSU)) begin
            state_d = S_IDLE;
            grant_d = G_NONE;
        end
    end

    always_comb begin
        m.arvalid   = (state_q == S_ADDR);
        m.araddr    = (grant_q == G_LSU) ? lsu.araddr : ifu.araddr;
        m.rready    = rready_sel;
        ifu.arready = (state_q == S_ADDR) && (grant_q == G_IFU) && m.arready;
        lsu.arready = (state_q == S_ADDR) && (grant_q == G_LSU) && m.arready;
        ifu.rvalid  = busy && (grant_q == G_IFU) && m.rvalid;
        lsu.rvalid  = busy && (grant_q == G_LSU) && m.rvalid;
        ifu.rdata   = m.rdata;
        lsu.rdata   = m.rdata;
        ifu.rresp   = m.rresp;
        lsu.rresp   = m.rresp;
    end
endmodule

// File: tb/tb_axi_rd_arbiter_rv32.sv
// Directed bench for axi_rd_arbiter_rv32: transaction-level owner model checked every
// negedge, plus literal expectations at key points of each scenario.
module tb_axi_rd_arbiter_rv32;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    axi_rd_arbiter_rv32_if #(.DATA_LEN(32)) ifu_if ();
    axi_rd_arbiter_rv32_if #(.DATA_LEN(32)) lsu_if ();
    axi_rd_arbiter_rv32_if #(.DATA_LEN(32)) m_if ();

    axi_rd_arbiter_rv32 #(.DATA_LEN(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifu   (ifu_if),
        .lsu   (lsu_if),
        .m     (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", nm, $time, act, exp);
        end
    endtask

    // Model: who owns the slave (0 none, 1 IFU, 2 LSU) and whether its address was taken.
    int owner;
    bit addr_taken;
    bit last_was_lsu;

    function automatic logic owner_rready();
        return (owner == 1) ? ifu_if.rready : lsu_if.rready;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner        <= 0;
            addr_taken   <= 1'b0;
            last_was_lsu <= 1'b0;
        end else if (owner == 0) begin
            addr_taken <= 1'b0;
            if (lsu_if.arvalid && ifu_if.arvalid) owner <= (RR && last_was_lsu) ? 1 : 2;
            else if (lsu_if.arvalid)              owner <= 2;
            else if (ifu_if.arvalid)              owner <= 1;
        end else begin
            if ((addr_taken || m_if.arready) && m_if.rvalid && owner_rready()) begin
                last_was_lsu <= (owner == 2);
                owner        <= 0;
                addr_taken   <= 1'b0;
            end else if (m_if.arready) begin
                addr_taken <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        logic e_arv, e_irv, e_lrv;
        e_arv = (owner != 0) && !addr_taken;
        e_irv = (owner == 1) && m_if.rvalid;
        e_lrv = (owner == 2) && m_if.rvalid;
        chk("m_arvalid", m_if.arvalid, e_arv);
        if (e_arv) chk("m_araddr", m_if.araddr, (owner == 2) ? lsu_if.araddr : ifu_if.araddr);
        chk("ifu_arready", ifu_if.arready, e_arv && owner == 1 && m_if.arready);
        chk("lsu_arready", lsu_if.arready, e_arv && owner == 2 && m_if.arready);
        chk("ifu_rvalid", ifu_if.rvalid, e_irv);
        chk("lsu_rvalid", lsu_if.rvalid, e_lrv);
        chk("m_rready", m_if.rready, (owner != 0) && owner_rready());
        if (e_irv) begin
            chk("ifu_rdata", ifu_if.rdata, m_if.rdata);
            chk("ifu_rresp", {29'd0, ifu_if.rresp}, {29'd0, m_if.rresp});
        end
        if (e_lrv) begin
            chk("lsu_rdata", lsu_if.rdata, m_if.rdata);
            chk("lsu_rresp", {29'd0, lsu_if.rresp}, {29'd0, m_if.rresp});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle with the requests already present; returns in the bubble cycle.
    task automatic xact(input int who, input logic [31:0] addr, input logic [31:0] data,
                        input bit drop);
        step();
        m_if.arready = 1'b1;
        #1;
        chk("x_m_arvalid", m_if.arvalid, 1);
        chk("x_m_araddr", m_if.araddr, addr);
        chk("x_ifu_arready", ifu_if.arready, who == 1);
        chk("x_lsu_arready", lsu_if.arready, who == 2);
        step();
        m_if.arready = 1'b0;
        m_if.rvalid  = 1'b1;
        m_if.rdata   = data;
        m_if.rresp   = 3'd0;
        if (drop) begin
            if (who == 1) ifu_if.arvalid = 1'b0;
            else          lsu_if.arvalid = 1'b0;
        end
        #1;
        chk("x_ifu_rvalid", ifu_if.rvalid, who == 1);
        chk("x_lsu_rvalid", lsu_if.rvalid, who == 2);
        chk("x_ifu_rdata", ifu_if.rdata, data);
        chk("x_lsu_rdata", lsu_if.rdata, data);
        step();
        m_if.rvalid = 1'b0;
        #1;
        chk("x_bubble_arvalid", m_if.arvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        ifu_if.arvalid = 1'b0; ifu_if.araddr = '0; ifu_if.rready = 1'b0;
        lsu_if.arvalid = 1'b0; lsu_if.araddr = '0; lsu_if.rready = 1'b0;
        m_if.arready = 1'b0; m_if.rvalid = 1'b0; m_if.rresp = 3'd0; m_if.rdata = '0;
        step();
        step();
        chk("rst_m_arvalid", m_if.arvalid, 0);
        chk("rst_ifu_arready", ifu_if.arready, 0);
        chk("rst_lsu_rvalid", lsu_if.rvalid, 0);
        rst_n = 1'b1;

        // Single IFU read, slave accepts the address on the second ADDR cycle.
        step();
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0000; ifu_if.rready = 1'b1;
        #1;
        chk("t1_idle_arready", ifu_if.arready, 0);
        step();
        #1;
        chk("t1_m_arvalid", m_if.arvalid, 1);
        chk("t1_m_araddr", m_if.araddr, 32'h8000_0000);
        chk("t1_arready_wait", ifu_if.arready, 0);
        step();
        m_if.arready = 1'b1;
        #1;
        chk("t1_ifu_arready", ifu_if.arready, 1);
        step();
        ifu_if.arvalid = 1'b0; m_if.arready = 1'b0;
        m_if.rvalid = 1'b1; m_if.rdata = 32'h0000_0413; m_if.rresp = 3'd0;
        #1;
        chk("t1_ifu_rvalid", ifu_if.rvalid, 1);
        chk("t1_ifu_rdata", ifu_if.rdata, 32'h0000_0413);
        chk("t1_lsu_rvalid", lsu_if.rvalid, 0);
        step();
        m_if.rvalid = 1'b0;
        #1;
        chk("t1_done_arvalid", m_if.arvalid, 0);

        // Simultaneous requests: LSU first, IFU one cycle after LSU completion.
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0004;
        lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_1000; lsu_if.rready = 1'b1;
        xact(2, 32'h8000_1000, 32'h0000_1111, 1'b1);
        xact(1, 32'h8000_0004, 32'h0000_2222, 1'b1);

        // Both keep requesting for three transactions: round robin alternates.
        ifu_if.arvalid = 1'b1; lsu_if.arvalid = 1'b1;
        xact(2, 32'h8000_1000, 32'h0000_3333, 1'b0);
        xact(RR ? 1 : 2, RR ? 32'h8000_0004 : 32'h8000_1000, 32'h0000_4444, 1'b0);
        xact(2, 32'h8000_1000, 32'h0000_5555, 1'b1);
        ifu_if.arvalid = 1'b0;

        // Address and data in the same cycle, with an error response.
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_0008;
        step();
        m_if.arready = 1'b1; m_if.rvalid = 1'b1; m_if.rresp = 3'b010; m_if.rdata = 32'hDEAD_BEEF;
        #1;
        chk("t4_ifu_arready", ifu_if.arready, 1);
        chk("t4_ifu_rvalid", ifu_if.rvalid, 1);
        chk("t4_ifu_rresp", {29'd0, ifu_if.rresp}, 32'd2);
        step();
        ifu_if.arvalid = 1'b0; m_if.arready = 1'b0;
        #1;
        chk("t4_idle_rvalid", ifu_if.rvalid, 0);
        chk("t4_idle_arvalid", m_if.arvalid, 0);
        m_if.rvalid = 1'b0; m_if.rresp = 3'd0;

        // LSU back-pressure for three cycles in DATA.
        lsu_if.arvalid = 1'b1; lsu_if.araddr = 32'h8000_1004; lsu_if.rready = 1'b0;
        step();
        m_if.arready = 1'b1;
        #1;
        chk("t5_lsu_arready", lsu_if.arready, 1);
        step();
        lsu_if.arvalid = 1'b0; m_if.arready = 1'b0; m_if.rvalid = 1'b1; m_if.rdata = 32'h55;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t5_bp_m_rready", m_if.rready, 0);
            chk("t5_bp_lsu_rvalid", lsu_if.rvalid, 1);
            step();
        end
        lsu_if.rready = 1'b1;
        #1;
        chk("t5_m_rready", m_if.rready, 1);
        step();
        #1;
        chk("t5_idle_lsu_rvalid", lsu_if.rvalid, 0);
        m_if.rvalid = 1'b0;

        // Reset while in DATA, then a normal IFU read.
        ifu_if.arvalid = 1'b1; ifu_if.araddr = 32'h8000_000C; ifu_if.rready = 1'b0;
        step();
        m_if.arready = 1'b1;
        step();
        ifu_if.arvalid = 1'b0; m_if.arready = 1'b0; m_if.rvalid = 1'b1;
        #1;
        chk("t6_data_ifu_rvalid", ifu_if.rvalid, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_m_arvalid", m_if.arvalid, 0);
        chk("t6_rst_ifu_rvalid", ifu_if.rvalid, 0);
        chk("t6_rst_lsu_rvalid", lsu_if.rvalid, 0);
        chk("t6_rst_ifu_arready", ifu_if.arready, 0);
        chk("t6_rst_lsu_arready", lsu_if.arready, 0);
        m_if.rvalid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        ifu_if.arvalid = 1'b1; ifu_if.rready = 1'b1;
        xact(1, 32'h8000_000C, 32'h0000_0077, 1'b1);
        step();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
